// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: evaluates conditional branches one cycle after execute and
// trains a table of 2-bit saturating counters that drives the fetch-stage prediction.
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic             Branch,
    input  logic             flush,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  A,
    input  logic [XLEN-1:0]  B,
    input  logic [XLEN-1:0]  imm,
    input  logic [2:0]       funct3,
    input  logic             ex_pred,
    output logic             res_valid,
    output logic             BrTaken,
    output logic [XLEN-1:0]  br_target,
    output logic             mispredict,
    output logic             illegal,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    function automatic logic branch_cond(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b);
        logic r;
        case (f3)
            3'b000:  r = (a == b);
            3'b001:  r = (a != b);
            3'b100:  r = ($signed(a) <  $signed(b));
            3'b101:  r = ($signed(a) >= $signed(b));
            3'b110:  r = (a <  b);
            3'b111:  r = (a >= b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] sat2_update(input logic [1:0] c, input logic up);
        logic [1:0] r;
        if (up) begin
            r = (c == 2'b11) ? c : c + 2'b01;
        end else begin
            r = (c == 2'b00) ? c : c - 2'b01;
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    logic [1:0]       bht_r [BHT_ENTRIES];
    logic             res_valid_r;
    logic             br_taken_r;
    logic [XLEN-1:0]  br_target_r;
    logic             mispredict_r;
    logic             illegal_r;
    logic [CNT_W-1:0] br_count_r;
    logic [CNT_W-1:0] mp_count_r;

    logic             accept_s;
    logic             illegal_s;
    logic             update_s;
    logic             taken_s;
    logic             mispredict_s;
    logic [IDX_W-1:0] ex_idx_s;
    logic [IDX_W-1:0] fetch_idx_s;
    logic [XLEN-1:0]  target_s;
    logic             unused_fetch_bits_s;

    // Decode the execute-stage branch: acceptance, legality, outcome and target.
    always_comb begin
        accept_s     = 1'b0;
        illegal_s    = 1'b0;
        update_s     = 1'b0;
        taken_s      = 1'b0;
        mispredict_s = 1'b0;
        accept_s     = ex_valid & Branch & ~flush;
        illegal_s    = (funct3[2:1] == 2'b01);
        update_s     = accept_s & ~illegal_s;
        taken_s      = branch_cond(funct3, A, B);
        if (illegal_s) begin
            mispredict_s = 1'b0;
        end else begin
            mispredict_s = taken_s ^ ex_pred;
        end
    end

    assign ex_idx_s    = ex_pc[IDX_W+1:2];
    assign fetch_idx_s = fetch_pc[IDX_W+1:2];
    assign target_s    = ex_pc + imm;

    // Only the index bits of the fetch PC select a predictor entry.
    assign unused_fetch_bits_s = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0]};

    // Reads the stored counter, so a same-cycle update is not yet visible.
    assign pred_taken = bht_r[fetch_idx_s][1];

    // Result registers, predictor training and statistics; reset wins over acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= 2'b01;
            end
            res_valid_r  <= 1'b0;
            br_taken_r   <= 1'b0;
            br_target_r  <= '0;
            mispredict_r <= 1'b0;
            illegal_r    <= 1'b0;
            br_count_r   <= '0;
            mp_count_r   <= '0;
        end else begin
            res_valid_r  <= accept_s;
            br_taken_r   <= accept_s & taken_s & ~illegal_s;
            mispredict_r <= accept_s & mispredict_s;
            illegal_r    <= accept_s & illegal_s;
            if (accept_s) begin
                br_target_r <= target_s;
            end
            if (update_s) begin
                bht_r[ex_idx_s] <= sat2_update(bht_r[ex_idx_s], taken_s);
                br_count_r      <= sat_inc(br_count_r);
                if (mispredict_s) begin
                    mp_count_r <= sat_inc(mp_count_r);
                end
            end
        end
    end

    assign res_valid  = res_valid_r;
    assign BrTaken    = br_taken_r;
    assign br_target  = br_target_r;
    assign mispredict = mispredict_r;
    assign illegal    = illegal_r;
    assign br_count   = br_count_r;
    assign mp_count   = mp_count_r;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a default 32-bit instance and a 64-bit,
// 4-entry, 2-bit-counter instance share sign-extended stimulus.
module tb_branch_resolve_unit;
    typedef struct {
        logic        v;
        logic        br;
        logic        fl;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pred;
        logic        e_valid;
        logic        e_taken;
        logic        e_mp;
        logic        e_ill;
        logic [31:0] e_tgt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_pc, ex_pc, A, B, imm;
    logic        ex_valid, Branch, flush, ex_pred;
    logic [2:0]  funct3;

    logic [63:0] fetch_pc64, ex_pc64, A64, B64, imm64;
    assign fetch_pc64 = {{32{fetch_pc[31]}}, fetch_pc};
    assign ex_pc64    = {{32{ex_pc[31]}}, ex_pc};
    assign A64        = {{32{A[31]}}, A};
    assign B64        = {{32{B[31]}}, B};
    assign imm64      = {{32{imm[31]}}, imm};

    logic        pred_taken, res_valid, BrTaken, mispredict, illegal;
    logic [31:0] br_target;
    logic [15:0] br_count, mp_count;
    logic        s_pred_taken, s_res_valid, s_BrTaken, s_mispredict, s_illegal;
    logic [63:0] s_br_target;
    logic [1:0]  s_br_count, s_mp_count;

    branch_resolve_unit dut (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .Branch(Branch), .flush(flush), .ex_pc(ex_pc),
        .A(A), .B(B), .imm(imm), .funct3(funct3), .ex_pred(ex_pred),
        .res_valid(res_valid), .BrTaken(BrTaken), .br_target(br_target),
        .mispredict(mispredict), .illegal(illegal), .br_count(br_count), .mp_count(mp_count)
    );

    branch_resolve_unit #(.XLEN(64), .BHT_ENTRIES(4), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc64), .pred_taken(s_pred_taken),
        .ex_valid(ex_valid), .Branch(Branch), .flush(flush), .ex_pc(ex_pc64),
        .A(A64), .B(B64), .imm(imm64), .funct3(funct3), .ex_pred(ex_pred),
        .res_valid(s_res_valid), .BrTaken(s_BrTaken), .br_target(s_br_target),
        .mispredict(s_mispredict), .illegal(s_illegal), .br_count(s_br_count),
        .mp_count(s_mp_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int exp_br = 0;
    int exp_mp = 0;
    logic [31:0] last_tgt;
    logic [63:0] last_tgt64;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic chk_counts(input string tag);
        chk({tag, " br_count"}, 64'(br_count), 64'(exp_br));
        chk({tag, " mp_count"}, 64'(mp_count), 64'(exp_mp));
        chk({tag, " s_br_count"}, 64'(s_br_count), 64'(sat3(exp_br)));
        chk({tag, " s_mp_count"}, 64'(s_mp_count), 64'(sat3(exp_mp)));
    endtask

    task automatic drive(input logic v, input logic br, input logic fl, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                         input logic [31:0] im, input logic pr);
        ex_valid = v; Branch = br; flush = fl; funct3 = f3;
        A = a; B = b; ex_pc = pc; imm = im; ex_pred = pr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic br, input logic fl, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                                input logic [31:0] im, input logic pr, input logic ev,
                                input logic et, input logic em, input logic ei,
                                input logic [31:0] tg);
        vec_t r;
        r.v = v; r.br = br; r.fl = fl; r.f3 = f3; r.a = a; r.b = b; r.pc = pc; r.imm = im;
        r.pred = pr; r.e_valid = ev; r.e_taken = et; r.e_mp = em; r.e_ill = ei; r.e_tgt = tg;
        return r;
    endfunction

    initial begin
        logic [63:0] tgt64;
        logic [3:0]  exp_pred;
        vecs[0]  = mk(1, 1, 0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 0, 1, 1, 1, 0, 32'h120);
        vecs[1]  = mk(1, 1, 0, 3'b100, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h8, 1, 1, 1, 0, 0, 32'h208);
        vecs[2]  = mk(1, 1, 0, 3'b110, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h8, 1, 1, 0, 1, 0, 32'h208);
        vecs[3]  = mk(1, 1, 0, 3'b101, 32'h80000000, 32'h80000000, 32'h300, 32'hFFFFFFFC, 1,
                      1, 1, 0, 0, 32'h2FC);
        vecs[4]  = mk(1, 1, 0, 3'b001, 32'd3, 32'd4, 32'h10, 32'h10, 0, 1, 1, 1, 0, 32'h20);
        vecs[5]  = mk(1, 1, 0, 3'b111, 32'd1, 32'd2, 32'hFFFFFFF0, 32'h20, 0, 1, 0, 0, 0, 32'h10);
        vecs[6]  = mk(1, 1, 0, 3'b010, 32'd7, 32'd7, 32'h400, 32'h4, 1, 1, 0, 0, 1, 32'h404);
        vecs[7]  = mk(1, 1, 1, 3'b000, 32'd9, 32'd9, 32'h500, 32'h4, 0, 0, 0, 0, 0, 32'h0);
        vecs[8]  = mk(0, 1, 0, 3'b000, 32'd9, 32'd9, 32'h500, 32'h4, 0, 0, 0, 0, 0, 32'h0);
        vecs[9]  = mk(1, 0, 0, 3'b000, 32'd9, 32'd9, 32'h500, 32'h4, 0, 0, 0, 0, 0, 32'h0);
        vecs[10] = mk(1, 1, 0, 3'b011, 32'd1, 32'd2, 32'h600, 32'h8, 0, 1, 0, 0, 1, 32'h608);
        vecs[11] = mk(1, 1, 0, 3'b000, 32'd1, 32'd2, 32'h700, 32'h10, 1, 1, 0, 1, 0, 32'h710);

        // Reset state
        rst_n = 1'b0; fetch_pc = 32'h40; idle();
        step(); step();
        chk("rst res_valid", 64'(res_valid), 64'd0);
        chk("rst br_target", 64'(br_target), 64'd0);
        chk("rst s_br_target", s_br_target, 64'd0);
        chk("rst pred_taken", 64'(pred_taken), 64'd0);
        chk_counts("rst");
        rst_n = 1'b1;
        last_tgt = 32'h0; last_tgt64 = 64'h0;

        // Table vectors, applied back to back
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v, vecs[i].br, vecs[i].fl, vecs[i].f3, vecs[i].a, vecs[i].b,
                  vecs[i].pc, vecs[i].imm, vecs[i].pred);
            step();
            tgt64 = {{32{vecs[i].pc[31]}}, vecs[i].pc} + {{32{vecs[i].imm[31]}}, vecs[i].imm};
            if (vecs[i].e_valid) begin
                last_tgt = vecs[i].e_tgt;
                last_tgt64 = tgt64;
            end
            if (vecs[i].e_valid && !vecs[i].e_ill) exp_br++;
            if (vecs[i].e_mp) exp_mp++;
            chk($sformatf("v%0d res_valid", i), 64'(res_valid), 64'(vecs[i].e_valid));
            chk($sformatf("v%0d BrTaken", i), 64'(BrTaken), 64'(vecs[i].e_taken));
            chk($sformatf("v%0d mispredict", i), 64'(mispredict), 64'(vecs[i].e_mp));
            chk($sformatf("v%0d illegal", i), 64'(illegal), 64'(vecs[i].e_ill));
            chk($sformatf("v%0d br_target", i), 64'(br_target), 64'(last_tgt));
            chk($sformatf("v%0d s_res_valid", i), 64'(s_res_valid), 64'(vecs[i].e_valid));
            chk($sformatf("v%0d s_BrTaken", i), 64'(s_BrTaken), 64'(vecs[i].e_taken));
            chk($sformatf("v%0d s_mispredict", i), 64'(s_mispredict), 64'(vecs[i].e_mp));
            chk($sformatf("v%0d s_illegal", i), 64'(s_illegal), 64'(vecs[i].e_ill));
            chk($sformatf("v%0d s_br_target", i), s_br_target, last_tgt64);
            chk_counts($sformatf("v%0d", i));
        end
        idle();
        step();
        chk("pulse end res_valid", 64'(res_valid), 64'd0);
        chk("pulse end br_target", 64'(br_target), 64'(last_tgt));

        // Predictor training at 0x40 from a fresh table
        rst_n = 1'b0; step(); rst_n = 1'b1;
        exp_br = 0; exp_mp = 0;
        fetch_pc = 32'h40;
        exp_pred = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 0, 3'b000, 32'd1, 32'd1, 32'h40, 32'h8, exp_pred[k]);
            #1;
            chk($sformatf("bht k%0d pred_taken", k), 64'(pred_taken), 64'(exp_pred[k]));
            chk($sformatf("bht k%0d s_pred_taken", k), 64'(s_pred_taken), 64'(exp_pred[k]));
            step();
        end
        idle();
        #1;
        chk("bht sat pred_taken", 64'(pred_taken), 64'd1);
        chk("bht sat s_pred_taken", 64'(s_pred_taken), 64'd1);
        exp_br = 4; exp_mp = 1;
        chk_counts("bht");

        // Illegal operations must not train the table or count
        fetch_pc = 32'h48;
        drive(1, 1, 0, 3'b000, 32'd2, 32'd2, 32'h48, 32'h0, 0);
        step();
        drive(1, 1, 0, 3'b010, 32'd3, 32'd3, 32'h48, 32'h0, 1);
        step();
        chk("ill res_valid", 64'(res_valid), 64'd1);
        chk("ill illegal", 64'(illegal), 64'd1);
        chk("ill BrTaken", 64'(BrTaken), 64'd0);
        chk("ill mispredict", 64'(mispredict), 64'd0);
        drive(1, 1, 0, 3'b011, 32'd3, 32'd4, 32'h48, 32'h0, 1);
        step();
        idle();
        #1;
        chk("ill pred_taken", 64'(pred_taken), 64'd1);
        chk("ill s_pred_taken", 64'(s_pred_taken), 64'd1);
        exp_br = 5; exp_mp = 2;
        chk_counts("ill");

        // Reset during the result cycle clears state; reset overrides a pending acceptance
        fetch_pc = 32'h40;
        drive(1, 1, 0, 3'b000, 32'd6, 32'd6, 32'h40, 32'h10, 1);
        step();
        chk("rr res_valid", 64'(res_valid), 64'd1);
        chk("rr br_target", 64'(br_target), 64'h50);
        rst_n = 1'b0;
        step();
        exp_br = 0; exp_mp = 0;
        chk("rr2 res_valid", 64'(res_valid), 64'd0);
        chk("rr2 br_target", 64'(br_target), 64'd0);
        chk("rr2 s_br_target", s_br_target, 64'd0);
        chk("rr2 pred_taken", 64'(pred_taken), 64'd0);
        chk("rr2 s_pred_taken", 64'(s_pred_taken), 64'd0);
        chk_counts("rr2");
        rst_n = 1'b1; idle();
        step();
        chk("rr3 res_valid", 64'(res_valid), 64'd0);
        chk_counts("rr3");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
